// File: rtl/mmio_pkg.sv
// Shared definitions for the console/exit MMIO peripheral: default decode
// addresses, transmitter state encodings and the parity helper.
package mmio_pkg;

   localparam logic [31:0] PUTC_ADDR_DEF = 32'h8000_001c;
   localparam logic [31:0] EXIT_ADDR_DEF = 32'h8000_002c;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Even parity over one character: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Synchronous character FIFO with (log2(DEPTH)+1)-bit wrapping pointers.
// A pop in the same cycle frees a slot, so a push while full is accepted then.
module mmio_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer advance; both pointers wrap naturally through the extra MSB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_console_tx.sv
// Console/exit MMIO peripheral: PUTC writes are queued and sent as 8N1 serial
// frames on uart_txd; an EXIT write latches a code and exit_done follows once
// the line has drained.
// Build option: define MMIO_CONSOLE_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit.
module mmio_console_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] PUTC_ADDR  = PUTC_ADDR_DEF,
   parameter logic [31:0] EXIT_ADDR  = EXIT_ADDR_DEF,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wready,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        uart_txd,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic [7:0]  drop_cnt,
   output logic        exit_req,
   output logic [31:0] exit_code,
   output logic        exit_done
);

   localparam int            CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);

   tx_state_t     state, state_nxt;
   logic [CW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shift_reg, shift_nxt;
   logic          txd_q, txd_nxt;
   logic          baud_last;
   logic          pop;
   logic          putc_hit;
   logic          exit_hit;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic          unused_wstrb;
`ifdef MMIO_CONSOLE_PARITY_EN
   logic          par_reg;
`endif

   // Only byte lane 0 carries a character; the upper strobes are don't-care.
   assign unused_wstrb = ^wstrb[3:1];

   // Full 32-bit address match, so no aliasing into neighbouring words.
   assign putc_hit  = wready && (waddr == PUTC_ADDR) && wstrb[0];
   assign exit_hit  = wready && (waddr == EXIT_ADDR) && !exit_req;
   assign baud_last = (baud_cnt == '0);

   assign uart_txd  = txd_q;
   assign tx_busy   = !fifo_empty || (state != ST_IDLE);
   assign exit_done = exit_req && !tx_busy;

   mmio_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (putc_hit),
      .pop   (pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Exit latch (first write wins) and saturating count of characters lost to a full FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exit_req  <= 1'b0;
         exit_code <= '0;
         drop_cnt  <= '0;
      end else begin
         if (exit_hit) begin
            exit_req  <= 1'b1;
            exit_code <= wdata;
         end
         if (putc_hit && fifo_full && !pop && (drop_cnt != 8'hff))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Next-state, pop and look-ahead line level; txd is registered from the next state.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      shift_nxt = shift_reg;
      bit_nxt   = bit_idx;
      baud_nxt  = baud_last ? BAUD_MAX : baud_cnt - 1'b1;
      txd_nxt   = 1'b1;
      case (state)
         ST_IDLE: begin
            baud_nxt = BAUD_MAX;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_dout;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (baud_last) begin
               state_nxt = ST_DATA;
               bit_nxt   = 3'd0;
            end
         end
         ST_DATA: begin
            if (baud_last) begin
               if (bit_idx == 3'd7) begin
`ifdef MMIO_CONSOLE_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  bit_nxt   = bit_idx + 1'b1;
                  shift_nxt = {1'b0, shift_reg[7:1]};
               end
            end
         end
`ifdef MMIO_CONSOLE_PARITY_EN
         ST_PARITY: begin
            if (baud_last) state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            // Pop straight from the last stop clock so frames run back to back.
            if (baud_last) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_dout;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      case (state_nxt)
         ST_START:  txd_nxt = 1'b0;
         ST_DATA:   txd_nxt = shift_nxt[0];
`ifdef MMIO_CONSOLE_PARITY_EN
         ST_PARITY: txd_nxt = par_reg;
`endif
         default:   txd_nxt = 1'b1;
      endcase
   end

   // Transmitter control state; reset aborts any frame and drives the line high at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         txd_q    <= txd_nxt;
      end
   end

   // Character shifter; its contents are only meaningful while a frame is in flight.
   always_ff @(posedge clk) begin
      shift_reg <= shift_nxt;
   end

`ifdef MMIO_CONSOLE_PARITY_EN
   // Parity is captured from the whole character at pop time, before it is shifted out.
   always_ff @(posedge clk) begin
      if (pop) par_reg <= even_parity(fifo_dout);
   end
`endif

endmodule
